// File: rtl/ext_mem_arbiter.sv
// rtl/ext_mem_arbiter.sv - two-port arbiter sharing the external memory controller
module ext_mem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p0_cs_b,
    input  logic        p0_rnw,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p0_dout,
    output logic        p0_clken,
    input  logic        p1_cs_b,
    input  logic        p1_rnw,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_dout,
    output logic        p1_clken,
    output logic [15:0] rd_data,
    output logic        mem_cs_b,
    output logic        mem_rnw,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_dout,
    input  logic        mem_clken,
    input  logic [15:0] mem_din,
    output logic        busy,
    output logic        owner
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_nxt;
    logic   owner_q, owner_nxt;
    logic   last_owner, last_owner_nxt;
    logic   req0, req1, winner;
    logic   sel, active, done;

    assign req0 = !p0_cs_b;
    assign req1 = !p1_cs_b;

    always_comb begin
        if (req0 && req1) begin
            winner = FIXED_PRIO ? 1'b0 : !last_owner;
        end else begin
            winner = req1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner_q    <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            owner_q    <= owner_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // Grant is decided in the IDLE cycle itself so that cycle is already access cycle 0.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner_q;
        last_owner_nxt = last_owner;
        sel            = 1'b0;
        active         = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    active    = 1'b1;
                    sel       = winner;
                    owner_nxt = winner;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                active = 1'b1;
                sel    = owner_q;
                if (mem_clken) begin
                    done           = 1'b1;
                    last_owner_nxt = owner_q;
                    state_nxt      = IDLE;
                end
            end
        endcase
    end

    // A requesting port runs only on its own completion cycle; idle ports run freely.
    assign p0_clken = p0_cs_b || (active && !sel && done);
    assign p1_clken = p1_cs_b || (active &&  sel && done);

    assign mem_cs_b = !active;
    assign mem_rnw  = sel ? p1_rnw  : p0_rnw;
    assign mem_addr = sel ? p1_addr : p0_addr;
    assign mem_dout = sel ? p1_dout : p0_dout;
    assign rd_data  = mem_din;
    assign busy     = (state == BUSY);
    assign owner    = owner_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb/tb_ext_mem_arbiter.sv - scoreboard bench for ext_mem_arbiter with a byte-RAM controller model
module tb_ext_mem_arbiter;

    typedef struct {
        logic        rnw;
        logic [15:0] addr;
        logic [15:0] data;
    } op_t;

    typedef struct {
        logic        port;
        logic        rnw;
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        p0_cs_b = 1'b1, p0_rnw = 1'b1, p1_cs_b = 1'b1, p1_rnw = 1'b1;
    logic [15:0] p0_addr = '0, p0_dout = '0, p1_addr = '0, p1_dout = '0;
    logic        p0_clken, p1_clken, mem_cs_b, mem_rnw, mem_clken, busy, owner;
    logic [15:0] rd_data, mem_addr, mem_dout, mem_din;

    logic        f_p0_cs_b = 1'b1, f_p1_cs_b = 1'b1;
    logic        f_p0_clken, f_p1_clken, f_mem_cs_b, f_mem_rnw, f_mem_clken, f_busy, f_owner;
    logic [15:0] f_rd_data, f_mem_addr, f_mem_dout;
    logic [15:0] f_mem_din;

    logic [7:0]  ram [0:131071];
    logic [2:0]  cnt, fcnt;

    op_t  q0[$], q1[$];
    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc_n = 0;
    int   base;

    always #5 clock = ~clock;

    ext_mem_arbiter u_dut (
        .clock(clock), .reset(reset),
        .p0_cs_b(p0_cs_b), .p0_rnw(p0_rnw), .p0_addr(p0_addr), .p0_dout(p0_dout), .p0_clken(p0_clken),
        .p1_cs_b(p1_cs_b), .p1_rnw(p1_rnw), .p1_addr(p1_addr), .p1_dout(p1_dout), .p1_clken(p1_clken),
        .rd_data(rd_data), .mem_cs_b(mem_cs_b), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .mem_clken(mem_clken), .mem_din(mem_din), .busy(busy), .owner(owner)
    );

    ext_mem_arbiter #(.FIXED_PRIO(1'b1)) u_fix (
        .clock(clock), .reset(reset),
        .p0_cs_b(f_p0_cs_b), .p0_rnw(1'b1), .p0_addr(16'h0001), .p0_dout(16'h0000), .p0_clken(f_p0_clken),
        .p1_cs_b(f_p1_cs_b), .p1_rnw(1'b1), .p1_addr(16'h0002), .p1_dout(16'h0000), .p1_clken(f_p1_clken),
        .rd_data(f_rd_data), .mem_cs_b(f_mem_cs_b), .mem_rnw(f_mem_rnw), .mem_addr(f_mem_addr),
        .mem_dout(f_mem_dout), .mem_clken(f_mem_clken), .mem_din(f_mem_din), .busy(f_busy), .owner(f_owner)
    );

    // Controller model: counts cycles of an asserted chip select, ready on the eighth.
    always_ff @(posedge clock) begin
        if (reset) cnt <= 3'd0;
        else if (!mem_cs_b) cnt <= cnt + 3'd1;
        if (reset) fcnt <= 3'd0;
        else if (!f_mem_cs_b) fcnt <= fcnt + 3'd1;
    end

    assign mem_clken   = !mem_cs_b && (cnt == 3'd7);
    assign mem_din     = {ram[{mem_addr, 1'b1}], ram[{mem_addr, 1'b0}]};
    assign f_mem_clken = !f_mem_cs_b && (fcnt == 3'd7);
    assign f_mem_din   = 16'h0000;

    function automatic logic [7:0] pat(input int i);
        return i[7:0] ^ i[15:8] ^ 8'h5C;
    endfunction

    function automatic logic [15:0] rd_pat(input logic [15:0] a);
        int b;
        b = 32'({a, 1'b0});
        return {pat(b + 1), pat(b)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic present(input logic port);
        if (!port) begin
            p0_cs_b = 1'b0; p0_rnw = q0[0].rnw; p0_addr = q0[0].addr; p0_dout = q0[0].data;
        end else begin
            p1_cs_b = 1'b0; p1_rnw = q1[0].rnw; p1_addr = q1[0].addr; p1_dout = q1[0].data;
        end
    endtask

    task automatic issue(input logic port, input logic rnw, input logic [15:0] addr, input logic [15:0] data);
        op_t o;
        o.rnw = rnw; o.addr = addr; o.data = data;
        if (!port) begin
            q0.push_back(o);
            if (p0_cs_b) present(1'b0);
        end else begin
            q1.push_back(o);
            if (p1_cs_b) present(1'b1);
        end
    endtask

    task automatic push_exp(input logic port, input logic rnw, input logic [15:0] addr,
                            input logic [15:0] data, input int cyc);
        exp_t e;
        e.port = port; e.rnw = rnw; e.addr = addr; e.data = data; e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Sample one cycle at the falling edge, then let the masters react just after the rising edge.
    task automatic cyc();
        logic c0, c1;
        exp_t e;
        @(negedge clock);
        c0 = !p0_cs_b && p0_clken;
        c1 = !p1_cs_b && p1_clken;
        if (p0_cs_b) chk1("idle_p0_clken", p0_clken, 1'b1);
        if (p1_cs_b) chk1("idle_p1_clken", p1_clken, 1'b1);
        if (!mem_cs_b && exp_q.size() > 0) begin
            chk("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
            chk1("mem_rnw", mem_rnw, exp_q[0].rnw);
            if (!exp_q[0].rnw) chk("mem_dout", 32'(mem_dout), 32'(exp_q[0].data));
        end
        if (c0 || c1) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL extra_completion: observed completion at cycle %0d expected none", cyc_n);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk1("done_port", c1, e.port);
                chk("done_cycle", cyc_n, e.cyc);
                if (e.rnw) chk("rd_data", 32'(rd_data), 32'(e.data));
            end
        end
        if (!mem_cs_b && mem_clken && !mem_rnw) begin
            ram[{mem_addr, 1'b0}] = mem_dout[7:0];
            ram[{mem_addr, 1'b1}] = mem_dout[15:8];
        end
        cyc_n++;
        @(posedge clock);
        #1;
        if (c0) begin
            void'(q0.pop_front());
            if (q0.size() > 0) present(1'b0); else p0_cs_b = 1'b1;
        end
        if (c1) begin
            void'(q1.pop_front());
            if (q1.size() > 0) present(1'b1); else p1_cs_b = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) ram[i] = pat(i);
        ram[17'h02468] = 8'h5A;
        ram[17'h02469] = 8'hA5;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk1("rst_mem_cs_b", mem_cs_b, 1'b1);
        chk1("rst_p0_clken", p0_clken, 1'b1);
        chk1("rst_p1_clken", p1_clken, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_owner", owner, 1'b0);

        // Simultaneous requests straight after reset: port 0 wins the first tie.
        base = cyc_n;
        push_exp(1'b0, 1'b1, 16'h1234, 16'hA55A, base + 7);
        push_exp(1'b1, 1'b1, 16'h0020, rd_pat(16'h0020), base + 15);
        issue(1'b0, 1'b1, 16'h1234, 16'h0000);
        issue(1'b1, 1'b1, 16'h0020, 16'h0000);
        repeat (18) cyc();
        chk("drain_tie", exp_q.size(), 0);

        // Single uncontended read.
        base = cyc_n;
        push_exp(1'b0, 1'b1, 16'h1234, 16'hA55A, base + 7);
        issue(1'b0, 1'b1, 16'h1234, 16'h0000);
        repeat (10) cyc();
        chk("drain_single", exp_q.size(), 0);

        // Continuous contention: port 0 was last, so port 1 leads and grants alternate.
        base = cyc_n;
        for (int k = 0; k < 4; k++) begin
            push_exp(1'b1, 1'b1, 16'h0200 + 16'(k), rd_pat(16'h0200 + 16'(k)), base + 7 + 16 * k);
            push_exp(1'b0, 1'b1, 16'h0100 + 16'(k), rd_pat(16'h0100 + 16'(k)), base + 15 + 16 * k);
        end
        for (int k = 0; k < 4; k++) begin
            issue(1'b0, 1'b1, 16'h0100 + 16'(k), 16'h0000);
            issue(1'b1, 1'b1, 16'h0200 + 16'(k), 16'h0000);
        end
        repeat (66) cyc();
        chk("drain_rr", exp_q.size(), 0);

        // Port 1 writes, port 0 reads the same word one cycle later.
        base = cyc_n;
        push_exp(1'b1, 1'b0, 16'h0010, 16'hBEEF, base + 7);
        push_exp(1'b0, 1'b1, 16'h0010, 16'hBEEF, base + 15);
        issue(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        cyc();
        issue(1'b0, 1'b1, 16'h0010, 16'h0000);
        repeat (17) cyc();
        chk("drain_wr_rd", exp_q.size(), 0);

        // Owner abandons its request at cycle 3; the access still runs to cycle 7.
        issue(1'b0, 1'b1, 16'h0100, 16'h0000);
        repeat (3) cyc();
        q0.delete();
        p0_cs_b = 1'b1;
        for (int k = 3; k < 8; k++) begin
            #1;
            chk1("drop_mem_cs_b", mem_cs_b, 1'b0);
            chk1("drop_busy", busy, 1'b1);
            cyc();
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            chk1("drop_no_retry", mem_cs_b, 1'b1);
            chk1("drop_idle_busy", busy, 1'b0);
            cyc();
        end

        // Reset pulsed at cycle 4 of an access.
        issue(1'b0, 1'b1, 16'h1234, 16'h0000);
        repeat (4) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        q0.delete();
        p0_cs_b = 1'b1;
        #1;
        chk1("rstmid_mem_cs_b", mem_cs_b, 1'b1);
        chk1("rstmid_p0_clken", p0_clken, 1'b1);
        chk1("rstmid_p1_clken", p1_clken, 1'b1);
        chk1("rstmid_busy", busy, 1'b0);
        base = cyc_n;
        push_exp(1'b1, 1'b1, 16'h0020, rd_pat(16'h0020), base + 7);
        issue(1'b1, 1'b1, 16'h0020, 16'h0000);
        repeat (10) cyc();
        chk("drain_after_rst", exp_q.size(), 0);

        // Fixed-priority instance: port 0 wins every tie, port 1 only once port 0 stops.
        f_p0_cs_b = 1'b0;
        f_p1_cs_b = 1'b0;
        for (int k = 0; k < 32; k++) begin
            #1;
            chk1("fix_p0_clken", f_p0_clken, (k % 8) == 7);
            chk1("fix_p1_stall", f_p1_clken, 1'b0);
            cyc();
        end
        f_p0_cs_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk1("fix_p1_clken", f_p1_clken, k == 7);
            cyc();
        end
        f_p1_cs_b = 1'b1;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
